// File: rtl/data_mem_arbiter_if.sv
// Bus bundle for data_mem_arbiter: MEM-stage port, debug dump port and memory port.
// slave is the arbiter's view; master is the surrounding pipeline/debug/memory view.
interface data_mem_arbiter_if #(
    parameter int unsigned len_data = 32,
    parameter int unsigned len_addr = 6
);
    logic                halt_flag;
    logic                pipe_rd;
    logic                pipe_wr;
    logic [len_addr-1:0] pipe_addr;
    logic [len_data-1:0] pipe_wdata;
    logic [len_data-1:0] pipe_rdata;
    logic                pipe_stall;
    logic                dump_req;
    logic [len_data-1:0] dbg_data;
    logic                dbg_valid;
    logic                dbg_ready;
    logic                dump_busy;
    logic                dump_done;
    logic                mem_rd;
    logic                mem_wr;
    logic [len_addr-1:0] mem_addr;
    logic [len_data-1:0] mem_wdata;
    logic [len_data-1:0] mem_rdata;

    modport slave (
        input  halt_flag, pipe_rd, pipe_wr, pipe_addr, pipe_wdata, dump_req, dbg_ready,
               mem_rdata,
        output pipe_rdata, pipe_stall, dbg_data, dbg_valid, dump_busy, dump_done,
               mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output halt_flag, pipe_rd, pipe_wr, pipe_addr, pipe_wdata, dump_req, dbg_ready,
               mem_rdata,
        input  pipe_rdata, pipe_stall, dbg_data, dbg_valid, dump_busy, dump_done,
               mem_rd, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Data memory arbiter: MEM-stage passthrough, or a word-by-word memory dump to the debug unit.
// Optional DUMP_CHECKSUM_EN appends an XOR checksum word after the last dumped word.
module data_mem_arbiter #(
    parameter int unsigned len_data  = 32,
    parameter int unsigned len_addr  = 6,
    parameter int unsigned mem_depth = 64
) (
    input logic                clk,
    input logic                reset,
    data_mem_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {
        StPipe,
        StRd,
        StLatch,
        StSend,
        StFin
`ifdef DUMP_CHECKSUM_EN
        , StCsum
`endif
    } state_e;

    localparam logic [len_addr-1:0] LastAddr = len_addr'(mem_depth - 1);

    state_e              state_q, state_d;
    logic [len_addr-1:0] addr_cnt_q, addr_cnt_d;
    logic [len_data-1:0] dbg_data_q, dbg_data_d;
`ifdef DUMP_CHECKSUM_EN
    logic [len_data-1:0] csum_q, csum_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StPipe;
            addr_cnt_q <= '0;
            dbg_data_q <= '0;
`ifdef DUMP_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            dbg_data_q <= dbg_data_d;
`ifdef DUMP_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_cnt_d     = addr_cnt_q;
        dbg_data_d     = dbg_data_q;
`ifdef DUMP_CHECKSUM_EN
        csum_d         = csum_q;
`endif
        // Dump owns the memory unless we are in StPipe.
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.mem_addr   = addr_cnt_q;
        bus.mem_wdata  = '0;
        bus.pipe_rdata = '0;
        bus.pipe_stall = 1'b1;
        bus.dump_busy  = 1'b1;
        bus.dbg_valid  = 1'b0;
        bus.dump_done  = 1'b0;
        bus.dbg_data   = dbg_data_q;

        case (state_q)
            StPipe: begin
                bus.mem_rd     = bus.pipe_rd;
                bus.mem_wr     = bus.pipe_wr;
                bus.mem_addr   = bus.pipe_addr;
                bus.mem_wdata  = bus.pipe_wdata;
                bus.pipe_rdata = bus.mem_rdata;
                bus.pipe_stall = 1'b0;
                bus.dump_busy  = 1'b0;
                if (bus.dump_req && bus.halt_flag) begin
                    state_d = StRd;
                end
            end
            StRd: begin
                bus.mem_rd = 1'b1;
`ifdef DUMP_CHECKSUM_EN
                if (addr_cnt_q == '0) begin
                    csum_d = '0;
                end
`endif
                state_d = StLatch;
            end
            StLatch: begin
                dbg_data_d = bus.mem_rdata;
`ifdef DUMP_CHECKSUM_EN
                csum_d     = csum_q ^ bus.mem_rdata;
`endif
                state_d    = StSend;
            end
            StSend: begin
                bus.dbg_valid = 1'b1;
                if (bus.dbg_ready) begin
                    if (addr_cnt_q == LastAddr) begin
`ifdef DUMP_CHECKSUM_EN
                        dbg_data_d = csum_q;
                        state_d    = StCsum;
`else
                        state_d    = StFin;
`endif
                    end else begin
                        addr_cnt_d = addr_cnt_q + len_addr'(1);
                        state_d    = StRd;
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            StCsum: begin
                bus.dbg_valid = 1'b1;
                if (bus.dbg_ready) begin
                    state_d = StFin;
                end
            end
`endif
            StFin: begin
                bus.dump_done = 1'b1;
                addr_cnt_d    = '0;
                state_d       = StPipe;
            end
            default: state_d = StPipe;
        endcase
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: passthrough vectors, full dumps via a scoreboard,
// back-pressure, ownership and mid-dump reset. Honours DUMP_CHECKSUM_EN.
module tb_data_mem_arbiter;
    localparam int Depth = 64;
`ifdef DUMP_CHECKSUM_EN
    localparam int ExpCycles = 3 * Depth + 2;
    localparam int ExpXfers  = Depth + 1;
`else
    localparam int ExpCycles = 3 * Depth + 1;
    localparam int ExpXfers  = Depth;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.len_data(32), .len_addr(6)) bus ();

    data_mem_arbiter #(.len_data(32), .len_addr(6), .mem_depth(Depth)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous single-port memory model: read data valid one cycle after mem_rd.
    logic [31:0] mem [Depth];
    logic [31:0] mem_rdata_r = '0;
    always @(posedge clk) begin
        if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd) mem_rdata_r <= mem[bus.mem_addr];
    end
    assign bus.mem_rdata = mem_rdata_r;

    int n_checks = 0;
    int n_pass   = 0;
    int n_xfer   = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: a transfer happens on the next edge when valid and ready are both high.
    always @(negedge clk) begin
        if (!reset && bus.dbg_valid && bus.dbg_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) check("dbg_unexpected_xfer", bus.dbg_data, 32'hx);
            else check("dbg_data", bus.dbg_data, exp_q.pop_front());
        end
    end

    task automatic push_dump();
        logic [31:0] x;
        x = '0;
        for (int i = 0; i < Depth; i++) begin
            exp_q.push_back(32'(i + 1));
            x = x ^ 32'(i + 1);
        end
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic wait_word(input logic [31:0] w, input string tag);
        int c;
        c = 0;
        while (!(bus.dbg_valid && bus.dbg_data == w) && c < 300) begin
            tick();
            c++;
        end
        check({tag, "_reached"}, 32'(c < 300), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (bus.dump_busy && c < 400) begin
            tick();
            c++;
        end
        check({tag, "_idle"}, 32'(bus.dump_busy), 32'd0);
    endtask

    task automatic full_dump(input string tag);
        int busy, dones, done_at, x0;
        busy = 0; dones = 0; done_at = 0;
        push_dump();
        x0 = n_xfer;
        bus.dump_req = 1'b1; bus.halt_flag = 1'b1; bus.dbg_ready = 1'b1;
        tick();
        bus.dump_req = 1'b0;
        check({tag, "_start_rd"}, 32'(bus.mem_rd), 32'd1);
        check({tag, "_start_addr"}, 32'(bus.mem_addr), 32'd0);
        for (int c = 0; c < 400 && bus.dump_busy; c++) begin
            busy++;
            if (bus.dump_done) begin
                dones++;
                done_at = busy;
            end
            tick();
        end
        check({tag, "_busy_cycles"}, 32'(busy), 32'(ExpCycles));
        check({tag, "_done_count"}, 32'(dones), 32'd1);
        check({tag, "_done_at"}, 32'(done_at), 32'(ExpCycles));
        check({tag, "_xfers"}, 32'(n_xfer - x0), 32'(ExpXfers));
        check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_back_in_pipe"}, 32'(bus.pipe_stall), 32'd0);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic        exp_rd;
        logic        exp_wr;
        logic [5:0]  exp_addr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 6'd5,  32'hDEADBEEF, 1'b0, 1'b1, 6'd5,  32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b0, 6'd5,  32'h0,        1'b1, 1'b0, 6'd5,  32'h0};
        vecs[2] = '{1'b0, 1'b1, 6'd63, 32'h12345678, 1'b0, 1'b1, 6'd63, 32'h12345678};
        vecs[3] = '{1'b1, 1'b0, 6'd0,  32'hA5A5A5A5, 1'b1, 1'b0, 6'd0,  32'hA5A5A5A5};

        reset = 1'b1;
        bus.halt_flag = 1'b0; bus.pipe_rd = 1'b0; bus.pipe_wr = 1'b0;
        bus.pipe_addr = '0; bus.pipe_wdata = '0; bus.dump_req = 1'b0; bus.dbg_ready = 1'b0;
        tick(); tick();
        check("rst_dbg_valid", 32'(bus.dbg_valid), 32'd0);
        check("rst_dump_busy", 32'(bus.dump_busy), 32'd0);
        check("rst_dump_done", 32'(bus.dump_done), 32'd0);
        check("rst_pipe_stall", 32'(bus.pipe_stall), 32'd0);
        check("rst_dbg_data", bus.dbg_data, 32'd0);
        reset = 1'b0;

        // Passthrough vectors.
        for (int i = 0; i < 4; i++) begin
            bus.pipe_rd = vecs[i].rd; bus.pipe_wr = vecs[i].wr;
            bus.pipe_addr = vecs[i].addr; bus.pipe_wdata = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_mem_rd", i), 32'(bus.mem_rd), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d_mem_wr", i), 32'(bus.mem_wr), 32'(vecs[i].exp_wr));
            check($sformatf("vec%0d_mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].exp_addr));
            check($sformatf("vec%0d_mem_wdata", i), bus.mem_wdata, vecs[i].exp_wdata);
            check($sformatf("vec%0d_stall", i), 32'(bus.pipe_stall), 32'd0);
            tick();
        end
        bus.pipe_rd = 1'b1; bus.pipe_wr = 1'b0; bus.pipe_addr = 6'd5;
        tick();
        bus.pipe_rd = 1'b0;
        check("pipe_readback_5", bus.pipe_rdata, 32'hDEADBEEF);

        // Preload word i = i + 1 through the MEM-stage port.
        for (int i = 0; i < Depth; i++) begin
            bus.pipe_wr = 1'b1; bus.pipe_addr = 6'(i); bus.pipe_wdata = 32'(i + 1);
            tick();
        end
        bus.pipe_wr = 1'b0;

        full_dump("dump1");

        // Request without halt waits; halt rising starts the dump on the next edge.
        push_dump();
        bus.halt_flag = 1'b0; bus.dump_req = 1'b1; bus.dbg_ready = 1'b1;
        begin
            int busy_seen;
            busy_seen = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (bus.dump_busy || bus.pipe_stall) busy_seen++;
            end
            check("nohalt_busy_cycles", 32'(busy_seen), 32'd0);
        end
        bus.halt_flag = 1'b1;
        tick();
        bus.dump_req = 1'b0;
        check("halt_rise_busy", 32'(bus.dump_busy), 32'd1);
        check("halt_rise_rd", 32'(bus.mem_rd), 32'd1);

        // Reset while word 20 (value 21) is on offer.
        wait_word(32'd21, "abort");
        reset = 1'b1;
        tick();
        check("abort_dbg_valid", 32'(bus.dbg_valid), 32'd0);
        check("abort_dump_busy", 32'(bus.dump_busy), 32'd0);
        check("abort_dbg_data", bus.dbg_data, 32'd0);
        reset = 1'b0;
        exp_q.delete();
        full_dump("restart");

        // Back-pressure on word 3 and a blocked pipeline write during the dump.
        push_dump();
        bus.dump_req = 1'b1; bus.halt_flag = 1'b1; bus.dbg_ready = 1'b1;
        tick();
        bus.dump_req = 1'b0;
        bus.pipe_wr = 1'b1; bus.pipe_addr = 6'd0; bus.pipe_wdata = 32'hFFFFFFFF;
        #1;
        check("own_mem_wr", 32'(bus.mem_wr), 32'd0);
        check("own_stall", 32'(bus.pipe_stall), 32'd1);
        check("own_pipe_rdata", bus.pipe_rdata, 32'd0);
        tick();
        bus.pipe_wr = 1'b0;
        wait_word(32'd4, "bp");
        bus.dbg_ready = 1'b0;
        begin
            int held;
            held = 0;
            for (int i = 0; i < 7; i++) begin
                tick();
                if (bus.dbg_valid && bus.dbg_data == 32'd4) held++;
            end
            check("bp_hold_cycles", 32'(held), 32'd7);
        end
        bus.dbg_ready = 1'b1;
        tick();
        check("bp_next_rd", 32'(bus.mem_rd), 32'd1);
        check("bp_next_addr", 32'(bus.mem_addr), 32'd4);
        wait_idle("bp");
        check("bp_queue_left", 32'(exp_q.size()), 32'd0);

        bus.pipe_rd = 1'b1; bus.pipe_addr = 6'd0;
        tick();
        bus.pipe_rd = 1'b0;
        check("word0_unchanged", bus.pipe_rdata, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Shares the single-port data memory between the MEM stage and the debug unit. After the pipeline halts, the block sequences a full memory dump to the debug unit, one word at a time, over a valid/ready handshake. While no dump is running, the block passes MEM-stage accesses straight through, so normal execution sees the memory unchanged.

Parameters:
len_data, 32, data word width
len_addr, 6, memory address width (word addressing)
mem_depth, 64, number of words dumped; must be at most 2**len_addr

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
halt_flag  input  1  pipeline halted (halt has reached MEM/WB)
pipe_rd  input  1  MEM-stage read enable
pipe_wr  input  1  MEM-stage write enable
pipe_addr  input  len_addr  MEM-stage word address
pipe_wdata  input  len_data  MEM-stage write data
pipe_rdata  output  len_data  read data returned to the MEM stage (mem_rdata passthrough)
pipe_stall  output  1  MEM stage must hold; memory is owned by the dump
dump_req  input  1  debug unit requests a dump (level)
dbg_data  output  len_data  dumped word
dbg_valid  output  1  dbg_data is valid
dbg_ready  input  1  debug unit accepts dbg_data
dump_busy  output  1  dump in progress
dump_done  output  1  one-cycle pulse when the last word is accepted
mem_rd  output  1  memory read enable
mem_wr  output  1  memory write enable
mem_addr  output  len_addr  memory address
mem_wdata  output  len_data  memory write data
mem_rdata  input  len_data  memory read data; valid 1 cycle after mem_rd

Behaviour:
- Reset: state=PIPE, addr_cnt=0; dbg_data=0; dbg_valid, dump_busy, dump_done, pipe_stall all 0. Reset in any state aborts the dump immediately. No partial word is presented after reset.
- PIPE: mem_rd/mem_wr/mem_addr/mem_wdata = pipe_* combinationally, and pipe_rdata = mem_rdata.
  - dump_req=1 and halt_flag=1: go to RD.
  - dump_req=1 and halt_flag=0: remain in PIPE until halt_flag rises. No stall in this case.
- RD: mem_rd=1, mem_wr=0, mem_addr=addr_cnt; next state LATCH. dump_busy=1 in RD, LATCH, SEND and FIN.
- LATCH: capture mem_rdata into dbg_data; next state SEND.
- SEND: dbg_valid=1; dbg_data stays stable until accepted.
  - dbg_ready=1 and addr_cnt=mem_depth-1: go to FIN.
  - dbg_ready=1 otherwise: addr_cnt++ and go to RD.
  - dbg_ready=0: hold.
  - A transfer completes only when dbg_valid and dbg_ready are both 1 on the same edge.
- FIN: dump_done=1 for exactly one cycle, addr_cnt returns to 0, next state PIPE.
- Ownership during a dump: in every state except PIPE, pipe_stall=1, pipe_wr/pipe_rd are ignored (mem_wr is forced 0), and pipe_rdata=0.
- Handshake latency: 3 cycles from a state entering RD to dbg_valid, assuming dbg_ready is already high.
- No stalls: with dbg_ready held at 1, one word is transferred every 3 cycles, so mem_depth words take 3*mem_depth+1 cycles including FIN.
- dump_req dropping mid-dump is ignored; the dump always runs to completion.
- A new dump starts only when dump_req is high in PIPE after FIN. A held dump_req with halt_flag still high restarts the dump immediately.
- addr_cnt is len_addr bits wide and never exceeds mem_depth-1.

Optional Feature:
Macro: DUMP_CHECKSUM_EN.
- Defined: a running XOR of every dumped word is reset at RD for address 0. After the last word is accepted, a CSUM state presents the XOR on dbg_data with dbg_valid=1, using the same handshake. FIN follows acceptance of the checksum word, so the total is mem_depth+1 transfers.
- Undefined: no checksum state or register; the dump is exactly mem_depth transfers.

Test Plan:
1. Reset, then pipe_wr=1, pipe_addr=5, pipe_wdata=0xDEADBEEF with halt_flag=0 -> mem_wr=1, mem_addr=5, pipe_stall=0; a later pipe_rd at address 5 returns 0xDEADBEEF.
2. Preload word i = i+1, halt_flag=1, dump_req=1, dbg_ready=1 -> 64 transfers of 1..64, dump_done pulses once 193 cycles after the request edge, and the block returns to PIPE.
3. dump_req=1 with halt_flag=0 for 10 cycles -> dump_busy stays 0; halt_flag rises -> RD is entered on the next edge.
4. dbg_ready held low for 7 cycles during SEND of word 3 -> dbg_valid stays 1 and dbg_data holds 4; addr_cnt advances only on acceptance.
5. During a dump, pulse pipe_wr=1 at addr 0 with data 0xFFFFFFFF -> mem_wr stays 0, pipe_stall=1, and word 0 is unchanged afterwards.
6. reset asserted in SEND at word 20 -> the next cycle shows dbg_valid=0 and dump_busy=0; a new dump restarts from address 0. With DUMP_CHECKSUM_EN, the 65th word equals the XOR of 1..64.
